bullet_hit_detector: RTL and testbench



---
 rtl/bullet_hit_detector.sv | 166 ++++++++++++++++
 tb/tb_bullet_hit_detector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bullet_hit_detector.sv
// Per-frame bullet/heart collision, HP bookkeeping, invincibility frames and death latch.
// Optional HIT_BLUE_RULE_EN: blue bullets only damage a heart that moved since the previous evaluation.
module bullet_hit_detector #(
  parameter int MAX_HP       = 20,
  parameter int DAMAGE       = 3,
  parameter int HEAL         = 1,
  parameter int IFRAME_TICKS = 60,
  parameter int HEART_SIZE   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameTick,
  input  logic        isRun,
  input  logic [15:0] heartPos,
  input  logic [15:0] position1,
  input  logic [15:0] position2,
  input  logic [15:0] size1,
  input  logic [15:0] size2,
  input  logic [2:0]  color1,
  input  logic [2:0]  color2,
  input  logic        isRender1,
  input  logic        isRender2,
  output logic [7:0]  hp,
  output logic        hit,
  output logic        healed,
  output logic        invincible,
  output logic        dead
);

  typedef enum logic [2:0] {IDLE, CAPTURE, EVAL, APPLY, DEAD} state_t;

  localparam logic [8:0] HS       = 9'(HEART_SIZE);
  localparam logic [7:0] MAX_HP_V = 8'(MAX_HP);
  localparam logic [7:0] DMG_V    = 8'(DAMAGE);
  localparam logic [8:0] HEAL_V   = 9'(HEAL);
  localparam logic [7:0] IFR_V    = 8'(IFRAME_TICKS);
  localparam logic [2:0] WHITE    = 3'b000;
  localparam logic [2:0] GREEN    = 3'b001;
  localparam logic [2:0] BLUE     = 3'b010;

  state_t      state;
  logic [15:0] heart_q, pos1_q, pos2_q, size1_q, size2_q;
  logic [2:0]  color1_q, color2_q;
  logic        render1_q, render2_q;
  logic        any_dmg, any_heal;
  logic [7:0]  iframe_cnt;
`ifdef HIT_BLUE_RULE_EN
  logic [15:0] prev_heart;
`endif

  logic       ov1, ov2, blue_ok, dmg_c, heal_c;
  logic       apply_hit, apply_heal;
  logic [8:0] heal_sum;
  logic [7:0] hp_apply;

  // 9-bit sums keep edges near 255 from wrapping; an empty box never overlaps
  function automatic logic overlap(input logic [15:0] pos, input logic [15:0] size,
                                   input logic [15:0] heart, input logic render);
    logic [8:0] bx, by, bw, bh, hx, hy;
    bx = {1'b0, pos[15:8]};
    by = {1'b0, pos[7:0]};
    bw = {1'b0, size[15:8]};
    bh = {1'b0, size[7:0]};
    hx = {1'b0, heart[15:8]};
    hy = {1'b0, heart[7:0]};
    return render && (bw != 9'd0) && (bh != 9'd0) &&
           (bx < hx + HS) && (hx < bx + bw) && (by < hy + HS) && (hy < by + bh);
  endfunction

  always_comb begin
    ov1 = overlap(pos1_q, size1_q, heart_q, render1_q);
    ov2 = overlap(pos2_q, size2_q, heart_q, render2_q);
`ifdef HIT_BLUE_RULE_EN
    blue_ok = (heart_q != prev_heart);
`else
    blue_ok = 1'b1;
`endif
    dmg_c  = (ov1 && (color1_q == WHITE || (color1_q == BLUE && blue_ok))) ||
             (ov2 && (color2_q == WHITE || (color2_q == BLUE && blue_ok)));
    heal_c = (ov1 && color1_q == GREEN) || (ov2 && color2_q == GREEN);

    apply_hit  = any_dmg && (iframe_cnt == 8'd0);
    apply_heal = !any_dmg && any_heal;
    heal_sum   = {1'b0, hp} + HEAL_V;
    hp_apply   = hp;
    if (apply_hit)
      hp_apply = (hp > DMG_V) ? hp - DMG_V : 8'd0;
    else if (apply_heal)
      hp_apply = (heal_sum >= {1'b0, MAX_HP_V}) ? MAX_HP_V : heal_sum[7:0];
  end

  assign invincible = (iframe_cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hp         <= MAX_HP_V;
      hit        <= 1'b0;
      healed     <= 1'b0;
      dead       <= 1'b0;
      iframe_cnt <= 8'd0;
      heart_q    <= '0;
      pos1_q     <= '0;
      pos2_q     <= '0;
      size1_q    <= '0;
      size2_q    <= '0;
      color1_q   <= '0;
      color2_q   <= '0;
      render1_q  <= 1'b0;
      render2_q  <= 1'b0;
      any_dmg    <= 1'b0;
      any_heal   <= 1'b0;
`ifdef HIT_BLUE_RULE_EN
      prev_heart <= '0;
`endif
    end else begin
      hit    <= 1'b0;
      healed <= 1'b0;
      if (frameTick && isRun && iframe_cnt != 8'd0)
        iframe_cnt <= iframe_cnt - 8'd1;
      case (state)
        IDLE:
          if (frameTick && isRun) state <= CAPTURE;
        CAPTURE: begin
          heart_q   <= heartPos;
          pos1_q    <= position1;
          pos2_q    <= position2;
          size1_q   <= size1;
          size2_q   <= size2;
          color1_q  <= color1;
          color2_q  <= color2;
          render1_q <= isRender1;
          render2_q <= isRender2;
`ifdef HIT_BLUE_RULE_EN
          prev_heart <= heart_q;
`endif
          state     <= EVAL;
        end
        EVAL: begin
          any_dmg  <= dmg_c;
          any_heal <= heal_c;
          state    <= APPLY;
        end
        APPLY: begin
          hp     <= hp_apply;
          hit    <= apply_hit;
          healed <= apply_heal;
          // a fresh hit's reload wins over a decrement in the same cycle
          if (apply_hit) iframe_cnt <= IFR_V;
          if (hp_apply == 8'd0) begin
            dead  <= 1'b1;
            state <= DEAD;
          end else begin
            state <= IDLE;
          end
        end
        DEAD: begin
          hp    <= 8'd0;
          state <= DEAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Randomized + directed bench for bullet_hit_detector against a frame-level HP/i-frame model.
module tb_bullet_hit_detector;

  logic        clk = 1'b0;
  logic        reset, frameTick, isRun;
  logic [15:0] heartPos, position1, position2, size1, size2;
  logic [2:0]  color1, color2;
  logic        isRender1, isRender2;
  logic [7:0]  hp;
  logic        hit, healed, invincible, dead;

  int n_vec  = 0;
  int n_miss = 0;

  int m_hp, m_iframe, m_dead, m_prev;

  bullet_hit_detector dut (
    .clk(clk), .reset(reset), .frameTick(frameTick), .isRun(isRun),
    .heartPos(heartPos), .position1(position1), .position2(position2),
    .size1(size1), .size2(size2), .color1(color1), .color2(color2),
    .isRender1(isRender1), .isRender2(isRender2),
    .hp(hp), .hit(hit), .healed(healed), .invincible(invincible), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ov(input int bx, by, bw, bh, hx, hy, input bit r);
    return r && bw > 0 && bh > 0 && bx < hx + 8 && hx < bx + bw && by < hy + 8 && hy < by + bh;
  endfunction

  function automatic bit is_dmg(input bit o, input logic [2:0] c, input bit moved);
`ifdef HIT_BLUE_RULE_EN
    return o && (c == 3'd0 || (c == 3'd2 && moved));
`else
    return o && (c == 3'd0 || c == 3'd2);
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frameTick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_hp = 20; m_iframe = 0; m_dead = 0; m_prev = 0;
    check_eq("rst_hp", hp, 20);
    check_eq("rst_hit", hit, 0);
    check_eq("rst_healed", healed, 0);
    check_eq("rst_inv", invincible, 0);
    check_eq("rst_dead", dead, 0);
  endtask

  task automatic run_frame(input logic [15:0] hpos, p1, s1, p2, s2,
                           input logic [2:0] c1, c2, input logic r1, r2, run);
    bit e_hit, e_heal, o1, o2, d, h, moved;
    e_hit = 0; e_heal = 0;
    if (run && m_iframe > 0) m_iframe--;
    if (run && !m_dead) begin
      moved  = (int'(hpos) != m_prev);
      m_prev = int'(hpos);
      o1 = ov(p1[15:8], p1[7:0], s1[15:8], s1[7:0], hpos[15:8], hpos[7:0], r1);
      o2 = ov(p2[15:8], p2[7:0], s2[15:8], s2[7:0], hpos[15:8], hpos[7:0], r2);
      d  = is_dmg(o1, c1, moved) || is_dmg(o2, c2, moved);
      h  = (o1 && c1 == 3'd1) || (o2 && c2 == 3'd1);
      if (d) begin
        if (m_iframe == 0) begin
          m_hp = (m_hp > 3) ? m_hp - 3 : 0;
          e_hit = 1; m_iframe = 60;
        end
      end else if (h) begin
        m_hp = (m_hp + 1 > 20) ? 20 : m_hp + 1;
        e_heal = 1;
      end
      if (m_hp == 0) m_dead = 1;
    end
    @(negedge clk);
    heartPos = hpos; position1 = p1; size1 = s1; color1 = c1; isRender1 = r1;
    position2 = p2; size2 = s2; color2 = c2; isRender2 = r2;
    isRun = run; frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
    @(negedge clk);
    heartPos = 16'($urandom); position1 = 16'($urandom); position2 = 16'($urandom);
    size1 = 16'($urandom); size2 = 16'($urandom);
    color1 = 3'($urandom); color2 = 3'($urandom);
    isRender1 = 1'($urandom); isRender2 = 1'($urandom);
    @(negedge clk);
    check_eq("pre_hit", hit, 0);
    @(negedge clk);
    check_eq("hit", hit, 32'(e_hit));
    check_eq("healed", healed, 32'(e_heal));
    check_eq("hp", hp, 32'(m_hp));
    check_eq("dead", dead, 32'(m_dead));
    check_eq("inv", invincible, 32'(m_iframe != 0));
    @(negedge clk);
    check_eq("hit_1cyc", hit, 0);
    check_eq("healed_1cyc", healed, 0);
  endtask

  localparam logic [15:0] HEART = 16'h2828;
  localparam logic [15:0] B_IN  = 16'h2C2C;
  localparam logic [15:0] SZ4   = 16'h0404;

  task automatic empty_frames(input int n, input logic [15:0] hpos);
    for (int i = 0; i < n; i++)
      run_frame(hpos, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; frameTick = 1'b0; isRun = 1'b0;
    heartPos = '0; position1 = '0; position2 = '0; size1 = '0; size2 = '0;
    color1 = '0; color2 = '0; isRender1 = 1'b0; isRender2 = 1'b0;
    do_reset();

    // boundaries: adjacency, zero width, slot invalid, fight inactive
    run_frame(HEART, 16'h302C, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    run_frame(HEART, B_IN, 16'h0004, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);

    // white hit then i-frames
    run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    check_eq("tp_first_hit_hp", hp, 17);
    for (int i = 0; i < 59; i++)
      run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    check_eq("tp_iframe_hp", hp, 17);
    run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check_eq("tp_iframe_end", invincible, 0);
    run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    check_eq("tp_second_hit_hp", hp, 14);

    // heals during i-frames, saturation, combined slots
    for (int i = 0; i < 8; i++)
      run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1);
    check_eq("tp_heal_sat", hp, 20);
    empty_frames(52, HEART);
    run_frame(HEART, B_IN, SZ4, 16'h2A2A, SZ4, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1);
    empty_frames(60, HEART);
    run_frame(HEART, B_IN, SZ4, 16'h2A2A, SZ4, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    empty_frames(60, HEART);

    // blue: stationary, then moved by one pixel
    run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1);
    empty_frames(60, HEART);
    run_frame(HEART + 16'h0100, B_IN, SZ4, B_IN, SZ4, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1);

    // death from full HP
    do_reset();
    for (int k = 0; k < 7; k++) begin
      run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
      if (k < 6) empty_frames(60, HEART);
    end
    check_eq("tp_dead", dead, 1);
    check_eq("tp_dead_hp", hp, 0);
    for (int i = 0; i < 62; i++)
      run_frame(HEART, B_IN, SZ4, B_IN, SZ4, 3'(i % 2), 3'd1, 1'b1, 1'b1, 1'b1);
    do_reset();

    // reset during an evaluation aborts it
    @(negedge clk);
    heartPos = HEART; position1 = B_IN; size1 = SZ4; color1 = 3'd0; isRender1 = 1'b1;
    isRun = 1'b1; frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_hit", hit, 0);
    end
    check_eq("abort_hp", hp, 20);
    m_hp = 20; m_iframe = 0; m_dead = 0; m_prev = 0;

    // randomized frames
    for (int i = 0; i < 700; i++) begin
      logic [15:0] hpos;
      hpos = {8'($urandom_range(36, 42)), 8'($urandom_range(36, 42))};
      if ($urandom_range(0, 1) == 0) hpos = 16'(m_prev);
      run_frame(hpos,
                {8'($urandom_range(28, 52)), 8'($urandom_range(28, 52))},
                {8'($urandom_range(0, 10)), 8'($urandom_range(0, 10))},
                {8'($urandom_range(28, 52)), 8'($urandom_range(28, 52))},
                {8'($urandom_range(0, 10)), 8'($urandom_range(0, 10))},
                3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 9) != 0));
      if (m_dead && $urandom_range(0, 7) == 0) do_reset();
      if (i % 100 == 99 && !m_dead) begin
        m_iframe = m_iframe;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
